// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control unit:
// opcodes, FSM states, datapath select codes and the control word.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADDR = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_REX     = 4'd6,
        S_RWB     = 4'd7,
        S_IEX     = 4'd8,
        S_IWB     = 4'd9,
        S_BRANCH  = 4'd10,
        S_JUMP    = 4'd11,
        S_TRAP    = 4'd12
    } state_t;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_SUB   = 2'b01,
        ALU_FUNCT = 2'b10
    } aluop_t;

    typedef enum logic [1:0] {
        SRCB_REG     = 2'b00,
        SRCB_FOUR    = 2'b01,
        SRCB_IMM     = 2'b10,
        SRCB_IMM_SH2 = 2'b11
    } srcb_t;

    typedef enum logic [1:0] {
        PC_ALU    = 2'b00,
        PC_ALUOUT = 2'b01,
        PC_JUMP   = 2'b10
    } pcsrc_t;

    typedef struct packed {
        logic   reg_dst;
        logic   alu_src_a;
        logic   i_or_d;
        logic   mem_to_reg;
        aluop_t alu_op;
        srcb_t  alu_src_b;
        pcsrc_t pc_source;
        logic   mem_read;
        logic   mem_write;
        logic   ir_write;
        logic   reg_write;
        logic   pc_write;
        logic   illegal;
    } ctrl_t;

    function automatic state_t dispatch(input logic [5:0] op);
        state_t s;
        s = S_TRAP;
        unique case (1'b1)
            op == OP_RTYPE:               s = S_REX;
            op == OP_LW || op == OP_SW:   s = S_MEMADDR;
            op == OP_BEQ:                 s = S_BRANCH;
            op == OP_J:                   s = S_JUMP;
            op == OP_ADDI:                s = S_IEX;
            default:                      s = S_TRAP;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational control-word decode from the current FSM state,
// with the memory handshake and zero-flag qualifiers applied.
module ctrl_decode
    import mips_ctrl_pkg::*;
(
    input  state_t state,
    input  logic   imem_ready,
    input  logic   alu_zero,
    output ctrl_t  ctrl
);

    always_comb begin
        ctrl = '0;
        unique case (state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.ir_write  = imem_ready;
                ctrl.pc_write  = imem_ready;
            end
            S_DECODE: begin
                ctrl.alu_src_b = SRCB_IMM_SH2;
            end
            S_MEMADDR, S_IEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
            end
            S_MEMRD: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
            end
            S_MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                ctrl.mem_write = 1'b1;
                ctrl.i_or_d    = 1'b1;
            end
            S_REX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_op    = ALU_FUNCT;
            end
            S_RWB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
            end
            S_IWB: begin
                ctrl.reg_write = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_op    = ALU_SUB;
                ctrl.pc_source = PC_ALUOUT;
                ctrl.pc_write  = alu_zero;
            end
            S_JUMP: begin
                ctrl.pc_source = PC_JUMP;
                ctrl.pc_write  = 1'b1;
            end
            S_TRAP: begin
                ctrl.illegal = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS control FSM: state register and next-state logic;
// the control word comes from ctrl_decode and is blanked during reset.
module multicycle_ctrl
    import mips_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] iopcode,
    input  logic       imem_ready,
    input  logic       iALU_zero,
    output logic       oSig_RegDst,
    output logic       oSig_ALUSrcA,
    output logic       oSig_IorD,
    output logic       oSig_MemToReg,
    output logic [1:0] oSig_ALUOp,
    output logic [1:0] oSig_ALUSrcB,
    output logic [1:0] oSig_PCSource,
    output logic       oSig_MemRead,
    output logic       oSig_MemWrite,
    output logic       oSig_IRWrite,
    output logic       oSig_RegWrite,
    output logic       oSig_PCWrite,
    output logic       oillegal,
    output logic [3:0] ostate
);

    state_t state;
    state_t state_n;
    ctrl_t  dec;
    ctrl_t  ctrl;

    always_comb begin
        state_n = state;
        unique case (state)
            S_FETCH:   if (imem_ready) state_n = S_DECODE;
            S_DECODE:  state_n = dispatch(iopcode);
            S_MEMADDR: state_n = (iopcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:   if (imem_ready) state_n = S_MEMWB;
            S_MEMWR:   if (imem_ready) state_n = S_FETCH;
            S_REX:     state_n = S_RWB;
            S_IEX:     state_n = S_IWB;
            S_MEMWB, S_RWB, S_IWB, S_BRANCH, S_JUMP:
                       state_n = S_FETCH;
            S_TRAP:    state_n = S_TRAP;
            default:   state_n = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_FETCH;
        else     state <= state_n;
    end

    ctrl_decode u_decode (
        .state      (state),
        .imem_ready (imem_ready),
        .alu_zero   (iALU_zero),
        .ctrl       (dec)
    );

    // FETCH decodes to MemRead=1, so reset must gate the word itself.
    assign ctrl = rst ? '0 : dec;

    assign oSig_RegDst   = ctrl.reg_dst;
    assign oSig_ALUSrcA  = ctrl.alu_src_a;
    assign oSig_IorD     = ctrl.i_or_d;
    assign oSig_MemToReg = ctrl.mem_to_reg;
    assign oSig_ALUOp    = ctrl.alu_op;
    assign oSig_ALUSrcB  = ctrl.alu_src_b;
    assign oSig_PCSource = ctrl.pc_source;
    assign oSig_MemRead  = ctrl.mem_read;
    assign oSig_MemWrite = ctrl.mem_write;
    assign oSig_IRWrite  = ctrl.ir_write;
    assign oSig_RegWrite = ctrl.reg_write;
    assign oSig_PCWrite  = ctrl.pc_write;
    assign oillegal      = ctrl.illegal;
    assign ostate        = rst ? 4'd0 : state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: per-instruction expected traces built
// from the instruction-level rules, checked every cycle, plus literals.
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] iopcode;
    logic       imem_ready;
    logic       iALU_zero;
    logic       oSig_RegDst, oSig_ALUSrcA, oSig_IorD, oSig_MemToReg;
    logic [1:0] oSig_ALUOp, oSig_ALUSrcB, oSig_PCSource;
    logic       oSig_MemRead, oSig_MemWrite, oSig_IRWrite;
    logic       oSig_RegWrite, oSig_PCWrite;
    logic       oillegal;
    logic [3:0] ostate;

    multicycle_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .iopcode       (iopcode),
        .imem_ready    (imem_ready),
        .iALU_zero     (iALU_zero),
        .oSig_RegDst   (oSig_RegDst),
        .oSig_ALUSrcA  (oSig_ALUSrcA),
        .oSig_IorD     (oSig_IorD),
        .oSig_MemToReg (oSig_MemToReg),
        .oSig_ALUOp    (oSig_ALUOp),
        .oSig_ALUSrcB  (oSig_ALUSrcB),
        .oSig_PCSource (oSig_PCSource),
        .oSig_MemRead  (oSig_MemRead),
        .oSig_MemWrite (oSig_MemWrite),
        .oSig_IRWrite  (oSig_IRWrite),
        .oSig_RegWrite (oSig_RegWrite),
        .oSig_PCWrite  (oSig_PCWrite),
        .oillegal      (oillegal),
        .ostate        (ostate)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       rdy;
        logic       zero;
        logic       regdst;
        logic       srca;
        logic       iord;
        logic       m2r;
        logic [1:0] aluop;
        logic [1:0] srcb;
        logic [1:0] pcsrc;
        logic       mrd;
        logic       mwr;
        logic       irw;
        logic       rw;
        logic       pcw;
        logic       ill;
    } step_t;

    step_t       plan_q[$];
    logic [15:0] act;
    logic [15:0] exp_vec;
    logic        chk_en = 1'b0;
    int          step_id;
    string       tag;
    int          n_cmp = 0;
    int          n_bad = 0;

    assign act = {oSig_RegDst, oSig_ALUSrcA, oSig_IorD, oSig_MemToReg,
                  oSig_ALUOp, oSig_ALUSrcB, oSig_PCSource,
                  oSig_MemRead, oSig_MemWrite, oSig_IRWrite,
                  oSig_RegWrite, oSig_PCWrite, oillegal};

    function automatic step_t blank(input logic rdy);
        step_t s;
        s = '0;
        s.rdy = rdy;
        return s;
    endfunction

    function automatic logic [15:0] word(input step_t s);
        return {s.regdst, s.srca, s.iord, s.m2r, s.aluop, s.srcb,
                s.pcsrc, s.mrd, s.mwr, s.irw, s.rw, s.pcw, s.ill};
    endfunction

    // Expected per-cycle trace of one instruction, from the ISA-level rules.
    task automatic plan_instr(input logic [5:0] op, input logic z,
                              input int fstall, input int mstall);
        step_t s;
        for (int i = 0; i <= fstall; i++) begin
            s = blank(i == fstall);
            s.mrd = 1'b1;
            s.srcb = 2'b01;
            s.irw = s.rdy;
            s.pcw = s.rdy;
            plan_q.push_back(s);
        end
        s = blank(1'b1);
        s.srcb = 2'b11;
        plan_q.push_back(s);
        if (op == 6'b100011 || op == 6'b101011) begin
            s = blank(1'b1);
            s.srca = 1'b1;
            s.srcb = 2'b10;
            plan_q.push_back(s);
            for (int i = 0; i <= mstall; i++) begin
                s = blank(i == mstall);
                s.iord = 1'b1;
                if (op == 6'b100011) s.mrd = 1'b1;
                else                 s.mwr = 1'b1;
                plan_q.push_back(s);
            end
            if (op == 6'b100011) begin
                s = blank(1'b1);
                s.rw = 1'b1;
                s.m2r = 1'b1;
                plan_q.push_back(s);
            end
        end else if (op == 6'b000000) begin
            s = blank(1'b1);
            s.srca = 1'b1;
            s.aluop = 2'b10;
            plan_q.push_back(s);
            s = blank(1'b1);
            s.rw = 1'b1;
            s.regdst = 1'b1;
            plan_q.push_back(s);
        end else if (op == 6'b001000) begin
            s = blank(1'b1);
            s.srca = 1'b1;
            s.srcb = 2'b10;
            plan_q.push_back(s);
            s = blank(1'b1);
            s.rw = 1'b1;
            plan_q.push_back(s);
        end else if (op == 6'b000100) begin
            s = blank(1'b1);
            s.zero = z;
            s.srca = 1'b1;
            s.aluop = 2'b01;
            s.pcsrc = 2'b01;
            s.pcw = z;
            plan_q.push_back(s);
        end else if (op == 6'b000010) begin
            s = blank(1'b1);
            s.pcsrc = 2'b10;
            s.pcw = 1'b1;
            plan_q.push_back(s);
        end else begin
            for (int i = 0; i < 6; i++) begin
                s = blank(i[0]);
                s.zero = i[1];
                s.ill = 1'b1;
                plan_q.push_back(s);
            end
        end
    endtask

    task automatic run_plan(input string name, input int limit);
        int n;
        n = (limit < plan_q.size()) ? limit : plan_q.size();
        tag = name;
        for (int i = 0; i < n; i++) begin
            imem_ready = plan_q[i].rdy;
            iALU_zero = plan_q[i].zero;
            exp_vec = word(plan_q[i]);
            step_id = i;
            chk_en = 1'b1;
            @(posedge clk);
            #1;
        end
        chk_en = 1'b0;
        plan_q.delete();
    endtask

    task automatic chk(input string name, input logic [15:0] got,
                       input logic [15:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    // Cycles from one instruction fetch to the next, imem_ready held high.
    task automatic measure(input string name, input logic [5:0] op,
                           input int want);
        int n;
        bit seen;
        n = 0;
        seen = 0;
        iopcode = op;
        imem_ready = 1'b1;
        iALU_zero = 1'b1;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            n++;
            if (n > 1 && oSig_IRWrite) seen = 1;
        end
        imem_ready = 1'b0;
        if (!seen) chk({name, "_timeout"}, 16'd0, 16'd1);
        else       chk(name, 16'(n - 1), 16'(want));
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            n_cmp++;
            if (act !== exp_vec) begin
                n_bad++;
                $display("FAIL ctrl_word %s step=%0d got=%h want=%h",
                         tag, step_id, act, exp_vec);
            end
            n_cmp++;
            if (oSig_MemRead && oSig_MemWrite) begin
                n_bad++;
                $display("FAIL mem_excl %s step=%0d got=11 want=not11",
                         tag, step_id);
            end
        end
    end

    initial begin
        rst = 1'b1;
        iopcode = 6'd0;
        imem_ready = 1'b0;
        iALU_zero = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_word", act, 16'h0000);
        chk("reset_state", {12'd0, ostate}, 16'h0000);
        @(negedge clk);
        chk("reset_word_neg", act, 16'h0000);
        @(posedge clk);
        #1;
        rst = 1'b0;

        iopcode = 6'b100011;
        plan_instr(6'b100011, 1'b0, 0, 0);
        run_plan("lw", 99);

        measure("cycles_lw", 6'b100011, 5);
        measure("cycles_sw", 6'b101011, 4);
        measure("cycles_rtype", 6'b000000, 4);
        measure("cycles_addi", 6'b001000, 4);
        measure("cycles_beq", 6'b000100, 3);
        measure("cycles_j", 6'b000010, 3);

        iopcode = 6'b000100;
        plan_instr(6'b000100, 1'b0, 0, 0);
        run_plan("beq_nt", 99);
        plan_instr(6'b000100, 1'b1, 0, 0);
        run_plan("beq_t", 99);

        iopcode = 6'b101011;
        plan_instr(6'b101011, 1'b0, 0, 3);
        run_plan("sw_stall", 99);

        iopcode = 6'b100011;
        plan_instr(6'b100011, 1'b0, 2, 1);
        run_plan("lw_stall", 99);
        iopcode = 6'b001000;
        plan_instr(6'b001000, 1'b0, 0, 0);
        run_plan("addi", 99);

        iopcode = 6'b000000;
        plan_instr(6'b000000, 1'b0, 0, 0);
        run_plan("rtype", 99);
        iopcode = 6'b000010;
        plan_instr(6'b000010, 1'b0, 0, 0);
        run_plan("j", 99);

        iopcode = 6'b100011;
        plan_instr(6'b100011, 1'b0, 0, 3);
        run_plan("lw_abort", 4);
        #1;
        chk("memrd_before_rst", {15'd0, oSig_MemRead}, 16'h0001);
        rst = 1'b1;
        #1;
        chk("abort_same_cycle", act, 16'h0000);
        @(negedge clk);
        chk("abort_hold", act, 16'h0000);
        @(posedge clk);
        #1;
        rst = 1'b0;
        iopcode = 6'b000010;
        plan_instr(6'b000010, 1'b0, 0, 0);
        run_plan("j_after_abort", 99);

        iopcode = 6'b111111;
        plan_instr(6'b111111, 1'b0, 0, 0);
        run_plan("trap", 99);
        #1;
        chk("trap_sticky", {15'd0, oillegal}, 16'h0001);
        rst = 1'b1;
        imem_ready = 1'b0;
        #1;
        chk("trap_rst_word", act, 16'h0000);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("trap_release", {14'd0, oSig_MemRead, oillegal}, 16'h0002);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 The block SHALL have the port rst, input, 1 bit: the reset, asynchronous and active-high.
REQ-003 The block SHALL have the port iopcode, input, 6 bits: instruction[31:26] from the instruction register.
REQ-004 The block SHALL have the port imem_ready, input, 1 bit: memory has completed the current access this cycle.
REQ-005 The block SHALL have the port iALU_zero, input, 1 bit: the ALU zero flag.
REQ-006 The block SHALL have the ports oSig_RegDst, oSig_ALUSrcA, oSig_IorD, oSig_MemToReg, output, 1 bit each: the datapath mux selects.
REQ-007 The block SHALL have the ports oSig_ALUOp, oSig_ALUSrcB, oSig_PCSource, output, 2 bits each: ALUOp coded 00 add, 01 sub, 10 funct; ALUSrcB coded 00 reg B, 01 const 4, 10 imm32, 11 imm32<<2; PCSource coded 00 ALU, 01 ALUOut, 10 jump.
REQ-008 The block SHALL have the ports oSig_MemRead, oSig_MemWrite, oSig_IRWrite, oSig_RegWrite, oSig_PCWrite, output, 1 bit each: the datapath write enables.
REQ-009 The block SHALL have the port oillegal, output, 1 bit: sticky flag set on an unsupported opcode.
REQ-010 The block SHALL have the port ostate, output, 4 bits: the current state encoding, for debug.

Function
REQ-011 The block SHALL be a Moore FSM whose outputs decode from the state, except that IRWrite, PCWrite and the memory-state exits are qualified by imem_ready, and PCWrite in BRANCH is qualified by iALU_zero.
REQ-012 The block SHALL implement states FETCH, DECODE, MEMADDR, MEMRD, MEMWB, MEMWR, REX, RWB, IEX, IWB, BRANCH, JUMP and TRAP.
REQ-013 In FETCH the block SHALL assert MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01 and ALUOp=00; when imem_ready=1 it SHALL also assert IRWrite=1 and PCWrite=1 with PCSource=00 and go to DECODE, otherwise it SHALL stay in FETCH.
REQ-014 In DECODE the block SHALL drive ALUSrcA=0, ALUSrcB=11 and ALUOp=00, and dispatch on the opcode: 000000 to REX; 100011 or 101011 to MEMADDR; 000100 to BRANCH; 000010 to JUMP; 001000 to IEX; any other value to TRAP.
REQ-015 In MEMADDR the block SHALL drive ALUSrcA=1, ALUSrcB=10 and ALUOp=00, then go to MEMRD for lw or MEMWR for sw.
REQ-016 In MEMRD the block SHALL drive MemRead=1 and IorD=1 until imem_ready, then go to MEMWB; MEMWB SHALL drive RegWrite=1, MemToReg=1 and RegDst=0, then go to FETCH.
REQ-017 In MEMWR the block SHALL drive MemWrite=1 and IorD=1 until imem_ready, then go to FETCH.
REQ-018 REX SHALL drive ALUSrcA=1, ALUSrcB=00 and ALUOp=10; RWB SHALL drive RegWrite=1, RegDst=1 and MemToReg=0; the path SHALL be REX to RWB to FETCH.
REQ-019 IEX SHALL drive ALUSrcA=1, ALUSrcB=10 and ALUOp=00; IWB SHALL drive RegWrite=1, RegDst=0 and MemToReg=0; the path SHALL be IEX to IWB to FETCH.
REQ-020 BRANCH SHALL drive ALUSrcA=1, ALUSrcB=00, ALUOp=01 and PCSource=01, assert PCWrite=iALU_zero, and then go to FETCH.
REQ-021 JUMP SHALL drive PCSource=10 and PCWrite=1, then go to FETCH.
REQ-022 TRAP SHALL be absorbing until reset, with all write enables 0 and oillegal=1.
REQ-023 Every output not listed for a state SHALL be 0, and MemRead and MemWrite SHALL never both be 1.
REQ-024 Cycle counts with imem_ready tied to 1 SHALL be: lw 5; sw 4; R-type 4; addi 4; beq 3; j 3.
REQ-025 Each cycle that imem_ready=0 SHALL add exactly one cycle of stall in FETCH, MEMRD or MEMWR, with all outputs held stable.

Reset
REQ-026 While rst=1 the block SHALL force every output to 0, set the state to FETCH and clear oillegal.
REQ-027 Reset asserted mid-access SHALL abort the access immediately, with no write enable asserted afterwards.
REQ-028 On the first clk edge after rst deasserts, the block SHALL present the FETCH outputs.

Structure
REQ-029 The opcode constants, the state encodings and the ALUOp, ALUSrcB and PCSource codes SHALL live in a shared package, mips_ctrl_pkg.
REQ-030 The design SHALL use one sub-module, ctrl_decode: combinational state/imem_ready/iALU_zero to control-word; the top holds only the state register and the next-state logic.

Verification
REQ-031 The bench SHALL cover: imem_ready=1, opcode 100011 -> states FETCH, DECODE, MEMADDR, MEMRD, MEMWB; RegWrite=1 only in cycle 5, with MemToReg=1.
REQ-032 The bench SHALL cover: opcode 000100 with iALU_zero=0, then a second pass with iALU_zero=1 -> PCWrite in BRANCH is 0 then 1, with PCSource=01; 3 cycles each.
REQ-033 The bench SHALL cover: opcode 101011 with imem_ready low for 3 cycles in MEMWR -> MemWrite held 1 for 4 cycles, RegWrite never 1.
REQ-034 The bench SHALL cover: opcode 111111 -> TRAP after DECODE, oillegal=1 indefinitely, no write enable; rst pulse -> FETCH, oillegal=0.
REQ-035 The bench SHALL cover: rst asserted asynchronously mid-MEMRD -> all outputs 0 within the same cycle, and FETCH after release.
REQ-036 The bench SHALL cover: back-to-back R-type then j -> RegDst=1 and ALUOp=10 in REX/RWB, then PCSource=10 with PCWrite=1 in JUMP; 7 cycles total.
